// File: rtl/enc_iter.sv
// ---------------------------------------------------------------------------
// enc_iter -- sequential bitmap-to-binary encoder
//
// Accepts an N-bit bitmap and emits the binary index of every set bit, one
// per accepted valid/ready handshake, lowest index first. Typical use is
// draining a mask of pending requests as encoded IDs into a consumer.
//
// Optional feature macro: ENC_ITER_BACK_TO_BACK_EN
//   undefined : o_vec_rdy only in IDLE (one idle cycle between bitmaps)
//   defined   : o_vec_rdy also on the cycle the final index is consumed,
//               giving zero-bubble throughput at the cost of a
//               combinational i_idx_rdy -> o_vec_rdy path
//
// Parameters
//   N           bitmap width (N >= 2)
//   W           index width, $clog2(N) (localparam)
//
// Ports
//   clk         in   1  clock
//   rst_n       in   1  synchronous reset, active-low
//   i_vec_vld   in   1  bitmap present on i_vec
//   i_vec       in   N  bitmap to encode
//   o_vec_rdy   out  1  block can accept a bitmap this cycle
//   o_idx_vld   out  1  o_idx valid
//   o_idx       out  W  binary index of lowest remaining set bit
//   o_idx_last  out  1  o_idx is the final set bit of the current bitmap
//   i_idx_rdy   in   1  consumer accepts o_idx
//   o_busy      out  1  bitmap in progress (state SCAN)
// ---------------------------------------------------------------------------
module enc_iter #(
    parameter int N = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_vec_vld,
    input  logic [N-1:0]         i_vec,
    output logic                 o_vec_rdy,
    output logic                 o_idx_vld,
    output logic [$clog2(N)-1:0] o_idx,
    output logic                 o_idx_last,
    input  logic                 i_idx_rdy,
    output logic                 o_busy
);

    localparam int W = $clog2(N);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   pend_q, pend_d;

    logic           scan;
    logic [W-1:0]   low_idx;
    logic           single;
    logic           consume;
    logic           accept;

    // Index of the lowest set bit; the descending scan lets the lowest
    // set bit overwrite any higher one. Returns 0 for an all-zero input,
    // which never reaches the output because SCAN always holds pend != 0.
    function automatic logic [W-1:0] lowest_idx(input logic [N-1:0] v);
        logic [W-1:0] idx;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = W'(i);
            end
        end
        return idx;
    endfunction

    // Exactly one bit set: clearing the lowest set bit leaves nothing.
    function automatic logic one_bit_set(input logic [N-1:0] v);
        return (v != '0) && ((v & (v - N'(1))) == '0);
    endfunction

    function automatic logic [N-1:0] bit_mask(input logic [W-1:0] idx);
        return N'(1) << idx;
    endfunction

    // Output decode from registered state only
    assign scan       = (state_q == SCAN);
    assign low_idx    = lowest_idx(pend_q);
    assign single     = one_bit_set(pend_q);

    assign o_idx_vld  = scan;
    assign o_idx      = low_idx;
    assign o_idx_last = scan & single;
    assign o_busy     = scan;

`ifdef ENC_ITER_BACK_TO_BACK_EN
    assign o_vec_rdy  = (state_q == IDLE) | (scan & single & i_idx_rdy);
`else
    assign o_vec_rdy  = (state_q == IDLE);
`endif

    assign consume    = o_idx_vld & i_idx_rdy;
    assign accept     = i_vec_vld & o_vec_rdy;

    // Next-state: consumption first, a new accept overrides it. In the
    // back-to-back build both can happen on one edge; the new bitmap
    // then replaces the (now empty) pending set.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;

        if (consume) begin
            pend_d = pend_q & ~bit_mask(low_idx);
            if (single) begin
                state_d = IDLE;
            end
        end

        if (accept) begin
            pend_d  = i_vec;
            state_d = (i_vec != '0) ? SCAN : IDLE;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

endmodule

// File: tb/tb_enc_iter.sv
// ---------------------------------------------------------------------------
// tb_enc_iter -- self-checking bench for enc_iter (N = 8)
//
// Every handshake on the index side is checked against a scoreboard queue
// filled when a bitmap is accepted. A table of bitmaps checks count, first
// index, final index and gap-free draining; hand-written sequences cover
// reset, backpressure, zero bitmaps, mid-scan reset and ignored loads.
// ---------------------------------------------------------------------------
module tb_enc_iter;

    localparam int N = 8;
    localparam int W = 3;

    logic         clk;
    logic         rst_n;
    logic         i_vec_vld;
    logic [N-1:0] i_vec;
    logic         o_vec_rdy;
    logic         o_idx_vld;
    logic [W-1:0] o_idx;
    logic         o_idx_last;
    logic         i_idx_rdy;
    logic         o_busy;

    enc_iter #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_vec_vld  (i_vec_vld),
        .i_vec      (i_vec),
        .o_vec_rdy  (o_vec_rdy),
        .o_idx_vld  (o_idx_vld),
        .o_idx      (o_idx),
        .o_idx_last (o_idx_last),
        .i_idx_rdy  (i_idx_rdy),
        .o_busy     (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] vec;
        int           cnt;
        int           first;
        int           last_idx;
    } vec_t;

    typedef struct {
        int idx;
        int last;
    } exp_t;

    exp_t sb_q[$];
    vec_t tbl[8];

    int checks;
    int errors;

    // Values sampled during the most recent cyc() call
    logic         s_vec_rdy, s_vld, s_last, s_busy;
    logic [W-1:0] s_idx;

    // Held-output tracking for backpressure
    logic         p_stall;
    logic [W-1:0] p_idx;
    logic         p_last;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Push expected indices of a freshly accepted bitmap
    task automatic sb_push(input logic [N-1:0] v);
        int hi;
        exp_t e;
        hi = -1;
        for (int b = 0; b < N; b++) if (v[b]) hi = b;
        for (int b = 0; b < N; b++) begin
            if (v[b]) begin
                e.idx  = b;
                e.last = (b == hi) ? 1 : 0;
                sb_q.push_back(e);
            end
        end
    endtask

    // One clock cycle: called #1 after a rising edge. Drives inputs,
    // samples outputs, scores any handshake, then advances to #1 after
    // the next rising edge.
    task automatic cyc(input logic vv, input logic [N-1:0] v, input logic rdy);
        exp_t e;
        i_vec_vld = vv;
        i_vec     = v;
        i_idx_rdy = rdy;
        #1;
        s_vec_rdy = o_vec_rdy;
        s_vld     = o_idx_vld;
        s_idx     = o_idx;
        s_last    = o_idx_last;
        s_busy    = o_busy;

        if (p_stall) begin
            check("hold_vld", int'(s_vld), 1);
            check("hold_idx", int'(s_idx), int'(p_idx));
            check("hold_last", int'(s_last), int'(p_last));
        end

        if (rst_n && s_vld && rdy) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_idx", int'(s_idx), -1);
            end else begin
                e = sb_q.pop_front();
                check("sb_idx", int'(s_idx), e.idx);
                check("sb_last", int'(s_last), e.last);
            end
        end
        if (rst_n && vv && s_vec_rdy) sb_push(v);

        p_stall = rst_n && s_vld && !rdy;
        p_idx   = s_idx;
        p_last  = s_last;

        @(posedge clk);
        #1;
    endtask

    // Drain with backpressure off, bounded by a cycle budget
    task automatic drain();
        int budget;
        budget = 40;
        while (sb_q.size() != 0 && budget > 0) begin
            cyc(1'b0, '0, 1'b1);
            budget--;
        end
        check("drain_timeout", sb_q.size(), 0);
        // let the block return to IDLE
        cyc(1'b0, '0, 1'b1);
    endtask

    initial begin
        int emitted, first_i, last_i, last_c;
        checks    = 0;
        errors    = 0;
        p_stall   = 1'b0;
        p_idx     = '0;
        p_last    = 1'b0;
        rst_n     = 1'b0;
        i_vec_vld = 1'b0;
        i_vec     = '0;
        i_idx_rdy = 1'b0;

        tbl[0] = '{8'h01, 1, 0, 0};
        tbl[1] = '{8'h80, 1, 7, 7};
        tbl[2] = '{8'hFF, 8, 0, 7};
        tbl[3] = '{8'hA4, 3, 2, 7};
        tbl[4] = '{8'h81, 2, 0, 7};
        tbl[5] = '{8'h18, 2, 3, 4};
        tbl[6] = '{8'h55, 4, 0, 6};
        tbl[7] = '{8'h00, 0, 0, 0};

        // Reset for two cycles
        repeat (2) @(posedge clk);
        #1;
        cyc(1'b0, '0, 1'b1);
        check("rst_idx_vld", int'(s_vld), 0);
        check("rst_busy", int'(s_busy), 0);
        check("rst_vec_rdy", int'(s_vec_rdy), 1);
        check("rst_idx_last", int'(s_last), 0);
        rst_n = 1'b1;
        cyc(1'b0, '0, 1'b1);

        // Basic drain of 1010_0100 with exact cycle timing
        cyc(1'b1, 8'hA4, 1'b1);
        check("t2_accept_rdy", int'(s_vec_rdy), 1);
        cyc(1'b0, '0, 1'b1);
        check("t2_idx0", int'(s_idx), 2);
        check("t2_vld0", int'(s_vld), 1);
        check("t2_last0", int'(s_last), 0);
        check("t2_rdy0", int'(s_vec_rdy), 0);
        cyc(1'b0, '0, 1'b1);
        check("t2_idx1", int'(s_idx), 5);
        check("t2_last1", int'(s_last), 0);
        cyc(1'b0, '0, 1'b1);
        check("t2_idx2", int'(s_idx), 7);
        check("t2_last2", int'(s_last), 1);
`ifdef ENC_ITER_BACK_TO_BACK_EN
        check("t2_rdy_on_last", int'(s_vec_rdy), 1);
`else
        check("t2_rdy_on_last", int'(s_vec_rdy), 0);
`endif
        cyc(1'b0, '0, 1'b1);
        check("t2_idle_vld", int'(s_vld), 0);
        check("t2_idle_rdy", int'(s_vec_rdy), 1);
        check("t2_idle_busy", int'(s_busy), 0);

        // Backpressure: index 2 held for three cycles
        cyc(1'b1, 8'hA4, 1'b1);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, '0, 1'b0);
            check("t3_stall_idx", int'(s_idx), 2);
            check("t3_stall_busy", int'(s_busy), 1);
        end
        drain();

        // Zero bitmap is swallowed, then single MSB
        cyc(1'b1, 8'h00, 1'b1);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, '0, 1'b1);
            check("t4_zero_vld", int'(s_vld), 0);
            check("t4_zero_busy", int'(s_busy), 0);
            check("t4_zero_rdy", int'(s_vec_rdy), 1);
        end
        cyc(1'b1, 8'h80, 1'b1);
        cyc(1'b0, '0, 1'b1);
        check("t4_msb_idx", int'(s_idx), 7);
        check("t4_msb_last", int'(s_last), 1);
        cyc(1'b0, '0, 1'b1);

        // Reset mid-scan discards remaining bits
        cyc(1'b1, 8'hFF, 1'b1);
        cyc(1'b0, '0, 1'b1);
        cyc(1'b0, '0, 1'b1);
        rst_n = 1'b0;
        cyc(1'b0, '0, 1'b1);
        rst_n = 1'b1;
        sb_q.delete();
        cyc(1'b0, '0, 1'b1);
        check("t5_post_rst_vld", int'(s_vld), 0);
        check("t5_post_rst_busy", int'(s_busy), 0);
        cyc(1'b1, 8'h01, 1'b1);
        cyc(1'b0, '0, 1'b1);
        check("t5_reload_idx", int'(s_idx), 0);
        check("t5_reload_last", int'(s_last), 1);
        cyc(1'b0, '0, 1'b1);
        check("t5_reload_done", int'(s_vld), 0);

        // Load attempt while scanning 0C
        cyc(1'b1, 8'h0C, 1'b1);
        cyc(1'b1, 8'hF0, 1'b1);
        check("t6_busy_rdy", int'(s_vec_rdy), 0);
        check("t6_idx0", int'(s_idx), 2);
`ifdef ENC_ITER_BACK_TO_BACK_EN
        cyc(1'b1, 8'hF0, 1'b1);
        check("t6_idx1", int'(s_idx), 3);
        check("t6_b2b_rdy", int'(s_vec_rdy), 1);
        for (int k = 4; k < 8; k++) begin
            cyc(1'b0, '0, 1'b1);
            check("t6_b2b_vld", int'(s_vld), 1);
            check("t6_b2b_idx", int'(s_idx), k);
        end
        cyc(1'b0, '0, 1'b1);
        check("t6_b2b_end", int'(s_vld), 0);
`else
        cyc(1'b0, '0, 1'b1);
        check("t6_idx1", int'(s_idx), 3);
        check("t6_idx1_last", int'(s_last), 1);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, '0, 1'b1);
            check("t6_ignored_vld", int'(s_vld), 0);
        end
`endif
        check("t6_sb_empty", sb_q.size(), 0);

        // Table of bitmaps: count, first, last, no bubbles
        for (int t = 0; t < 8; t++) begin
            cyc(1'b1, tbl[t].vec, 1'b1);
            emitted = 0;
            first_i = -1;
            last_i  = -1;
            last_c  = -1;
            for (int c = 0; c < 12; c++) begin
                cyc(1'b0, '0, 1'b1);
                if (s_vld) begin
                    if (emitted == 0) first_i = int'(s_idx);
                    if (s_last) last_i = int'(s_idx);
                    emitted++;
                    last_c = c;
                end else if (emitted > 0 || c >= 2) begin
                    break;
                end
            end
            check($sformatf("tbl%0d_cnt", t), emitted, tbl[t].cnt);
            if (tbl[t].cnt > 0) begin
                check($sformatf("tbl%0d_first", t), first_i, tbl[t].first);
                check($sformatf("tbl%0d_lastidx", t), last_i, tbl[t].last_idx);
                check($sformatf("tbl%0d_nobubble", t), last_c, tbl[t].cnt - 1);
            end
        end

        // Random traffic against the scoreboard
        for (int r = 0; r < 300; r++) begin
            cyc(1'($urandom_range(0, 1)), N'($urandom), 1'($urandom_range(0, 3) != 0));
        end
        drain();
        check("final_sb_empty", sb_q.size(), 0);
        check("final_idle_rdy", int'(s_vec_rdy), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
